mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_pkg.sv | 26 ++
 rtl/mult_div_unit.sv | 157 +++++++++++++++
 tb/tb_mult_div_unit.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_pkg.sv
// Shared op and FSM state encodings for the iterative multiply/divide unit
// and for any control-unit decode that issues work to it.
package mult_div_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic op_is_div(input op_t o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(input op_t o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one result bit per cycle, working on
// operand magnitudes with the sign fix-up folded into the final HI/LO load.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;   // partial product high half / running remainder
  logic [WIDTH-1:0] sh;    // multiplier bits / dividend-then-quotient bits
  logic [WIDTH-1:0] opnd;  // multiplicand or divisor magnitude
  logic             is_div;
  logic             neg_q;
  logic             neg_r;

  op_t              op_in;
  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             by_zero;

  assign op_in   = op_t'(op);
  assign sgn     = (SIGNED_EN != 1'b0) && op_is_signed(op_in);
  assign a_neg   = sgn & a[WIDTH-1];
  assign b_neg   = sgn & b[WIDTH-1];
  assign a_mag   = a_neg ? -a : a;
  assign b_mag   = b_neg ? -b : b;
  assign by_zero = op_is_div(op_in) && (b == '0);

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]   sh_nxt;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    addend  = sh[0] ? opnd : {WIDTH{1'b0}};
    mul_sum = {1'b0, acc} + {1'b0, addend};
    // Remainder stays below the divisor, so bit WIDTH of the trial is the borrow.
    trial   = {acc, sh[WIDTH-1]} - {1'b0, opnd};
    acc_nxt = mul_sum[WIDTH:1];
    sh_nxt  = {mul_sum[0], sh[WIDTH-1:1]};
    if (is_div) begin
      if (!trial[WIDTH]) begin
        acc_nxt = trial[WIDTH-1:0];
        sh_nxt  = {sh[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = {acc[WIDTH-2:0], sh[WIDTH-1]};
        sh_nxt  = {sh[WIDTH-2:0], 1'b0};
      end
    end
    prod     = {acc_nxt, sh_nxt};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -sh_nxt : sh_nxt;
    rem_fix  = neg_r ? -acc_nxt : acc_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      acc      <= '0;
      sh       <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          if (wr_hi) hi <= wr_data;
          if (wr_lo) lo <= wr_data;
          if (start) begin
            busy <= 1'b1;
            if (by_zero) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              state  <= ST_RUN;
              cnt    <= '0;
              acc    <= '0;
              sh     <= a_mag;
              opnd   <= b_mag;
              is_div <= op_is_div(op_in);
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
            end
          end
        end
        ST_RUN: begin
          acc <= acc_nxt;
          sh  <= sh_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= ST_DONE;
            done  <= 1'b1;
            cnt   <= '0;
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          div_zero <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          div_zero <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32): vector table, random
// operands against a 64-bit arithmetic model, and hand-written corner sequences.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, wr_hi, wr_lo;
  logic [1:0]   op;
  logic [W-1:0] a, b, wr_data;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  vec_t         vecs[$];
  logic [W-1:0] cur_hi, cur_lo;

  mult_div_unit #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Latency counts posedges from raising start, the sampling edge being 1.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    longint      sp, sq, sr;
    logic [63:0] up;
    e.dz = 1'b0;
    e.lat = W + 1;
    e.hi = cur_hi;
    e.lo = cur_lo;
    case (o)
      2'b00: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        {e.hi, e.lo} = 64'(sp);
      end
      2'b01: begin
        up = {32'h0, x} * {32'h0, y};
        {e.hi, e.lo} = up;
      end
      default: begin
        if (y == '0) begin
          e.dz = 1'b1;
          e.lat = 1;
        end else if (o == 2'b10) begin
          sq = longint'($signed(x)) / longint'($signed(y));
          sr = longint'($signed(x)) % longint'($signed(y));
          e.lo = sq[W-1:0];
          e.hi = sr[W-1:0];
        end else begin
          e.lo = x / y;
          e.hi = x % y;
        end
      end
    endcase
    return e;
  endfunction

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_op(input string name, input int lat);
    exp_t e;
    e = sb.pop_front();
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done_within_200", name);
    end else begin
      check({name, "_hi"}, 64'(hi), 64'(e.hi));
      check({name, "_lo"}, 64'(lo), 64'(e.lo));
      check({name, "_dz"}, 64'(div_zero), 64'(e.dz));
      check({name, "_lat"}, 64'(lat), 64'(e.lat));
    end
    @(posedge clk);
    #1;
    check({name, "_after"}, 64'({done, busy, div_zero}), 64'(0));
    cur_hi = e.hi;
    cur_lo = e.lo;
    $display("op %s: hi=0x%08h lo=0x%08h dz=%0b lat=%0d (exp hi=0x%08h lo=0x%08h)",
             name, hi, lo, div_zero, lat, e.hi, e.lo);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input exp_t e, input string name,
                        input logic whi, input logic [W-1:0] wdat);
    int lat;
    sb.push_back(e);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1; wr_hi = whi; wr_data = wdat;
    @(posedge clk);
    #1;
    start = 1'b0;
    wr_hi = 1'b0;
    check({name, "_busy"}, 64'(busy), 64'(1));
    wait_done(lat);
    finish_op(name, lat);
  endtask

  initial begin
    exp_t e;
    int   lat;
    int   done_seen;

    reset = 1'b1; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = 2'b00; a = '0; b = '0; wr_data = '0;
    cur_hi = '0; cur_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_state", 64'({busy, done, div_zero}), 64'(0));
    check("reset_hilo", {hi, lo}, 64'(0));

    vecs = '{
      '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
      '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1},
      '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
      '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
      '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14},
      '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD},
      '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
      '{2'b01, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000},
      '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001},
      '{2'b11, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF},
      '{2'b10, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2},
      '{2'b00, 32'h12345678, 32'd0,        32'h00000000, 32'h00000000}
    };
    foreach (vecs[i]) begin
      e.hi = vecs[i].hi;
      e.lo = vecs[i].lo;
      e.dz = 1'b0;
      e.lat = W + 1;
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, e, $sformatf("vec%0d", i), 1'b0, '0);
    end

    for (int i = 0; i < 8; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : W'($urandom_range(1, 1000));
      if (ro[1] && rb == '0) rb = 32'd1;
      run_op(ro, ra, rb, model(ro, ra, rb), $sformatf("rnd%0d", i), 1'b0, '0);
    end

    // Divide by zero: lo written alone, hi written in the same cycle as start.
    @(negedge clk);
    wr_lo = 1'b1; wr_data = 32'h22;
    @(posedge clk);
    #1;
    wr_lo = 1'b0;
    check("wr_lo_idle", 64'(lo), 64'h22);
    cur_lo = 32'h22;
    cur_hi = 32'h11;
    run_op(2'b11, 32'd100, 32'd0, model(2'b11, 32'd100, 32'd0), "divu_zero", 1'b1, 32'h11);

    // Start and writes pulsed mid-operation must be ignored.
    e = model(2'b01, 32'h1234, 32'h10);
    sb.push_back(e);
    @(negedge clk);
    op = 2'b01; a = 32'h1234; b = 32'h10; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    op = 2'b11; b = '0; start = 1'b1; wr_lo = 1'b1; wr_hi = 1'b1; wr_data = 32'h5;
    @(posedge clk);
    #1;
    start = 1'b0; wr_lo = 1'b0; wr_hi = 1'b0;
    lat = 7;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    finish_op("busy_ignore", lat);

    @(negedge clk);
    wr_hi = 1'b1; wr_data = 32'hAB;
    @(posedge clk);
    #1;
    wr_hi = 1'b0;
    check("wr_hi_idle", {hi, lo}, {32'hAB, cur_lo});
    $display("op wr_hi: hi=0x%08h lo=0x%08h", hi, lo);

    // Reset ten cycles into a multiply: no done, outputs cleared.
    @(negedge clk);
    op = 2'b00; a = 32'h1234; b = 32'h5678; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    @(negedge clk);
    reset = 1'b1; start = 1'b1; wr_hi = 1'b1; wr_data = 32'h77;
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0; wr_hi = 1'b0;
    check("abort_state", 64'({busy, done, div_zero}), 64'(0));
    check("abort_hilo", {hi, lo}, 64'(0));
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'(0));
    $display("op reset_abort: busy=%0b hi=0x%08h lo=0x%08h", busy, hi, lo);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
